// File: rtl/sar_search_ctrl.sv
// Binary-search controller resolving comparator operand B MSB-first, then verifying the final trial.
// Latency (WIDTH+1)*(SETTLE+1)+1 cycles from start to done; start is ignored while busy or in DONE.
module sar_search_ctrl #(
   parameter int WIDTH      = 4,
   parameter int SETTLE     = 1,
   parameter int EARLY_EXIT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] trial,
   input  logic             cmp_equal,
   input  logic             cmp_a_greater,
   input  logic             cmp_b_greater,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   localparam logic [IW-1:0]    IDX_MSB   = IW'(WIDTH - 1);
   localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE);
   localparam logic [WIDTH-1:0] TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_APPLY  = 2'd1;
   localparam logic [1:0] S_VERIFY = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    wait_cnt;
   logic             flags_ok;
   logic [WIDTH-1:0] trial_nxt;

   always_comb begin
      flags_ok = ({cmp_equal, cmp_a_greater, cmp_b_greater} == 3'b100) ||
                 ({cmp_equal, cmp_a_greater, cmp_b_greater} == 3'b010) ||
                 ({cmp_equal, cmp_a_greater, cmp_b_greater} == 3'b001);
   end

   // Decide the current bit and tentatively set the next lower one in the same step.
   always_comb begin
      trial_nxt = trial;
      if (cmp_a_greater) begin
         trial_nxt[idx] = 1'b0;
      end
      if (idx != '0) begin
         trial_nxt[idx - IW'(1)] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         wait_cnt <= '0;
         trial    <= '0;
         result   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         found    <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  trial    <= TRIAL_MSB;
                  idx      <= IDX_MSB;
                  wait_cnt <= SETTLE_LD;
                  found    <= 1'b0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_APPLY;
               end
            end
            S_APPLY, S_VERIFY: begin
               // Flags are only trusted once the settle window has fully elapsed.
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - CW'(1);
               end else if (!flags_ok) begin
                  err    <= 1'b1;
                  found  <= 1'b0;
                  result <= trial;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else if (state == S_VERIFY) begin
                  result <= trial;
                  found  <= cmp_equal;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else if ((EARLY_EXIT != 0) && cmp_equal) begin
                  result <= trial;
                  found  <= 1'b1;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  trial    <= trial_nxt;
                  wait_cnt <= SETTLE_LD;
                  if (idx == '0) begin
                     state <= S_VERIFY;
                  end else begin
                     idx <= idx - IW'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboarded bench for sar_search_ctrl: one instance without and one with early exit,
// each driven against its own combinational comparator model.
module tb_sar_search_ctrl;
   typedef struct {
      int result;
      int found;
      int err;
      int lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic       start0 = 1'b0, start1 = 1'b0;
   logic [3:0] b0 = 4'd0, b1 = 4'd0;
   logic       bad0 = 1'b0, bad1 = 1'b0;
   logic [3:0] trial0, trial1, result0, result1;
   logic       eq0, ag0, bg0, eq1, ag1, bg1;
   logic       busy0, busy1, done0, done1, found0, found1, err0, err1;

   assign eq0 = !bad0 && (trial0 == b0);
   assign ag0 = !bad0 && (trial0 >  b0);
   assign bg0 = !bad0 && (trial0 <  b0);
   assign eq1 = !bad1 && (trial1 == b1);
   assign ag1 = !bad1 && (trial1 >  b1);
   assign bg1 = !bad1 && (trial1 <  b1);

   sar_search_ctrl #(.WIDTH(4), .SETTLE(1), .EARLY_EXIT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .trial(trial0),
      .cmp_equal(eq0), .cmp_a_greater(ag0), .cmp_b_greater(bg0),
      .busy(busy0), .done(done0), .result(result0), .found(found0), .err(err0)
   );

   sar_search_ctrl #(.WIDTH(4), .SETTLE(1), .EARLY_EXIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .trial(trial1),
      .cmp_equal(eq1), .cmp_a_greater(ag1), .cmp_b_greater(bg1),
      .busy(busy1), .done(done1), .result(result1), .found(found1), .err(err1)
   );

   exp_t q0[$];
   exp_t q1[$];
   int   st0 = 0, st1 = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, req);
      end
   endtask

   task automatic score(input int inst, input int res, input int fnd, input int er, input int lat);
      exp_t e;
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL unexpected_done inst=%0d actual=done expected=no_done", inst);
         return;
      end
      if (inst == 0) e = q0.pop_front();
      else           e = q1.pop_front();
      check($sformatf("result%0d", inst),  res, e.result);
      check($sformatf("found%0d", inst),   fnd, e.found);
      check($sformatf("err%0d", inst),     er,  e.err);
      check($sformatf("latency%0d", inst), lat, e.lat);
   endtask

   // Monitor: every done pulse is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (done0) score(0, int'(result0), int'(found0), int'(err0), cyc - st0);
      if (done1) score(1, int'(result1), int'(found1), int'(err1), cyc - st1);
   end

   task automatic run(input int inst, input logic [3:0] b, input int res, input int fnd,
                      input int er, input int lat, input logic [15:0] trials,
                      input int bad_trial, input int pulse_at);
      exp_t       e;
      bit         fin;
      logic [3:0] cur;
      logic       dn, bz;
      fin = 1'b0;
      e.result = res;
      e.found  = fnd;
      e.err    = er;
      e.lat    = lat;
      @(posedge clk);
      #1;
      if (inst == 0) begin
         b0 = b; q0.push_back(e); st0 = cyc; start0 = 1'b1;
      end else begin
         b1 = b; q1.push_back(e); st1 = cyc; start1 = 1'b1;
      end
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      for (int r = 1; r <= 40 && !fin; r++) begin
         @(negedge clk);
         cur = (inst == 0) ? trial0 : trial1;
         dn  = (inst == 0) ? done0  : done1;
         bz  = (inst == 0) ? busy0  : busy1;
         if (r == 1) check($sformatf("busy%0d", inst), int'(bz), 1);
         if (trials != 16'h0 && r >= 2 && r <= 8 && (r % 2) == 0 && !dn)
            check($sformatf("trial%0d_r%0d", inst, r), int'(cur), int'(trials[15 - 4*(r/2 - 1) -: 4]));
         if (bad_trial >= 0 && int'(cur) == bad_trial) begin
            if (inst == 0) bad0 = 1'b1;
            else           bad1 = 1'b1;
         end
         if (r == pulse_at) begin
            if (inst == 0) start0 = 1'b1;
            else           start1 = 1'b1;
         end
         if (r == pulse_at + 1) begin
            start0 = 1'b0;
            start1 = 1'b0;
         end
         if (dn) fin = 1'b1;
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL timeout inst=%0d actual=no_done expected=done", inst);
      end
      bad0   = 1'b0;
      bad1   = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic reset_mid(input logic [3:0] b);
      @(posedge clk);
      #1;
      b0 = b;
      st0 = cyc;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_trial",  int'(trial0),  0);
      check("rst_result", int'(result0), 0);
      check("rst_busy",   int'(busy0),   0);
      check("rst_done",   int'(done0),   0);
      check("rst_found",  int'(found0),  0);
      check("rst_err",    int'(err0),    0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (15) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_trial",  int'(trial0),  0);
      check("reset_result", int'(result0), 0);
      check("reset_busy",   int'(busy0),   0);
      check("reset_done",   int'(done0),   0);
      check("reset_found",  int'(found0),  0);
      check("reset_err",    int'(err0),    0);
      check("reset_trial1", int'(trial1),  0);
      @(posedge clk);
      #1 rst = 1'b0;

      run(0, 4'd11, 11, 1, 0, 11, 16'h8CAB, -1, 0);
      run(0, 4'd0,   0, 1, 0, 11, 16'h8421, -1, 0);
      run(0, 4'd15, 15, 1, 0, 11, 16'h8CEF, -1, 0);
      run(0, 4'd13, 12, 0, 1,  5, 16'h8C00, 12, 0);
      run(0, 4'd13, 13, 1, 0, 11, 16'h8CED, -1, 0);
      run(0, 4'd6,   6, 1, 0, 11, 16'h8467, -1, 4);
      reset_mid(4'd9);
      run(0, 4'd3,   3, 1, 0, 11, 16'h8423, -1, 0);

      run(1, 4'd8,   8, 1, 0,  3, 16'h8000, -1, 0);
      run(1, 4'd5,   5, 1, 0,  9, 16'h8465, -1, 0);
      run(1, 4'd0,   0, 1, 0, 11, 16'h8421, -1, 0);

      repeat (3) @(posedge clk);
      check("pending0", q0.size(), 0);
      check("pending1", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
